// File: rtl/alu_op_driver.sv
// Sequencer between the control unit and the datapath ALU: issues one op, waits LATENCY edges,
// returns the captured result. Optional macro ALU_DRV_LOCAL_ZERO_EN derives rsp_zero from C_bus.
module alu_op_driver #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned LATENCY = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [DATA_W-1:0] A_bus,
  output logic [DATA_W-1:0] B_bus,
  output logic [OP_W-1:0]   operation,
  output logic              enable,
  input  logic [DATA_W-1:0] C_bus,
  input  logic              Z_flag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [15:0]       ops_done
);

  localparam int unsigned     CntW    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);
  localparam logic [OP_W-1:0] OpSub   = OP_W'(2);
  localparam logic [OP_W-1:0] OpMax   = OP_W'(11);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              en_q, en_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rzero_q, rzero_d;
  logic              rerr_q, rerr_d;
  logic              rvalid_q, rvalid_d;
  logic [15:0]       ops_q, ops_d;
  logic              op_legal;
  logic              zero_cap;

`ifdef ALU_DRV_LOCAL_ZERO_EN
  logic unused_z_flag;
  assign unused_z_flag = Z_flag;
  assign zero_cap      = (C_bus == '0);
`else
  // The ALU only defines Z_flag meaningfully for SUB.
  assign zero_cap = (op_q == OpSub) && Z_flag;
`endif

  assign op_legal = (req_op != '0) && (req_op <= OpMax);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    en_d      = en_q;
    rdata_d   = rdata_q;
    rzero_d   = rzero_q;
    rerr_d    = rerr_q;
    rvalid_d  = rvalid_q;
    ops_d     = ops_q;
    req_ready = (state_q == StIdle);

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (op_legal) begin
            a_d     = req_a;
            b_d     = req_b;
            op_d    = req_op;
            en_d    = 1'b1;
            cnt_d   = CntLoad;
            state_d = StExec;
          end else begin
            rdata_d  = '0;
            rzero_d  = 1'b0;
            rerr_d   = 1'b1;
            rvalid_d = 1'b1;
            state_d  = StResp;
          end
        end
      end
      StExec: begin
        if (cnt_q == '0) begin
          rdata_d  = C_bus;
          rzero_d  = zero_cap;
          rerr_d   = 1'b0;
          rvalid_d = 1'b1;
          en_d     = 1'b0;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rvalid_d = 1'b0;
          ops_d    = ops_q + 16'd1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      en_q     <= 1'b0;
      rdata_q  <= '0;
      rzero_q  <= 1'b0;
      rerr_q   <= 1'b0;
      rvalid_q <= 1'b0;
      ops_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      en_q     <= en_d;
      rdata_q  <= rdata_d;
      rzero_q  <= rzero_d;
      rerr_q   <= rerr_d;
      rvalid_q <= rvalid_d;
      ops_q    <= ops_d;
    end
  end

  assign A_bus     = a_q;
  assign B_bus     = b_q;
  assign operation = op_q;
  assign enable    = en_q;
  assign rsp_valid = rvalid_q;
  assign rsp_data  = rdata_q;
  assign rsp_zero  = rzero_q;
  assign rsp_err   = rerr_q;
  assign ops_done  = ops_q;

endmodule

// File: tb/tb_alu_op_driver.sv
// Directed bench for alu_op_driver with a behavioural ALU hanging off A_bus/B_bus/operation.
module tb_alu_op_driver;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [15:0] A_bus;
  logic [15:0] B_bus;
  logic [3:0]  operation;
  logic        enable;
  logic [15:0] C_bus;
  logic        Z_flag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_err;
  logic [15:0] ops_done;

  int checks = 0;
  int errors = 0;
  int en_cnt;
  int waited;
  logic exp_zero_add;

  alu_op_driver #(
    .DATA_W (16),
    .OP_W   (4),
    .LATENCY(5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_a    (req_a),
    .req_b    (req_b),
    .A_bus    (A_bus),
    .B_bus    (B_bus),
    .operation(operation),
    .enable   (enable),
    .C_bus    (C_bus),
    .Z_flag   (Z_flag),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_zero (rsp_zero),
    .rsp_err  (rsp_err),
    .ops_done (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in; Z_flag reflects a zero result for every opcode.
  always_comb begin
    C_bus = '0;
    case (operation)
      4'h1: C_bus = A_bus + B_bus;
      4'h2: C_bus = A_bus - B_bus;
      4'h3: C_bus = A_bus;
      4'h4: C_bus = B_bus;
      4'h5: C_bus = A_bus + 16'd1;
      4'h6: C_bus = A_bus - 16'd1;
      4'h7: C_bus = A_bus << 1;
      4'h8: C_bus = A_bus << 2;
      4'h9: C_bus = A_bus << 8;
      4'hA: C_bus = A_bus >> 4;
      default: C_bus = '0;
    endcase
    Z_flag = (C_bus == '0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one request for exactly one accepting edge; returns at the following negedge.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Waits (bounded) for rsp_valid, counting negedges on which enable was high.
  task automatic wait_rsp(output int n_en, output int n_wait);
    n_en   = 0;
    n_wait = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) break;
      if (enable) n_en++;
      n_wait++;
      @(negedge clk);
    end
    if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
`ifdef ALU_DRV_LOCAL_ZERO_EN
    exp_zero_add = 1'b1;
`else
    exp_zero_add = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_enable",    32'(enable),    32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_buses",     {A_bus, B_bus}, 32'd0);
    check("rst_op_data",   {12'd0, operation, rsp_data}, 32'd0);
    check("rst_flags",     {30'd0, rsp_zero, rsp_err}, 32'd0);
    check("rst_ops_done",  32'(ops_done),  32'd0);
    rst_n = 1'b1;

    // LSHIFT8 aborted by reset at the 3rd EXEC edge
    send(4'h9, 16'h00AB, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    check("abort_enable_before", 32'(enable), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_enable",    32'(enable),    32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_ops_done",  32'(ops_done),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_stay_idle", 32'(rsp_valid), 32'd0);

    // SUB 0x40-0x40, rsp_ready tied high
    rsp_ready = 1'b1;
    send(4'h2, 16'h0040, 16'h0040);
    wait_rsp(en_cnt, waited);
    check("sub_enable_cycles", 32'(en_cnt),  32'd5);
    check("sub_enable_low",    32'(enable),  32'd0);
    check("sub_data",          32'(rsp_data), 32'h0000);
    check("sub_zero",          32'(rsp_zero), 32'd1);
    check("sub_err",           32'(rsp_err),  32'd0);
    @(negedge clk);
    check("sub_rsp_valid_clr", 32'(rsp_valid), 32'd0);
    check("sub_ops_done",      32'(ops_done),  32'd1);
    check("sub_req_ready",     32'(req_ready), 32'd1);

    // ADD with consumer back-pressure
    rsp_ready = 1'b0;
    send(4'h1, 16'h1234, 16'h0F0F);
    check("add_req_ready_exec", 32'(req_ready), 32'd0);
    wait_rsp(en_cnt, waited);
    for (int i = 0; i < 3; i++) begin
      check("add_hold_data",  32'(rsp_data),  32'h2143);
      check("add_hold_valid", 32'(rsp_valid), 32'd1);
      check("add_hold_ready", 32'(req_ready), 32'd0);
      check("add_hold_bus",   {A_bus, B_bus}, 32'h1234_0F0F);
      check("add_hold_op",    32'(operation), 32'd1);
      @(negedge clk);
    end
    check("add_zero", 32'(rsp_zero), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("add_rsp_valid_clr", 32'(rsp_valid), 32'd0);
    check("add_req_ready",     32'(req_ready), 32'd1);
    check("add_ops_done",      32'(ops_done),  32'd2);

    // Illegal opcode 0xE
    send(4'hE, 16'h5555, 16'hAAAA);
    wait_rsp(en_cnt, waited);
    check("ill_at_accept", 32'(waited),   32'd0);
    check("ill_enable",    32'(enable),   32'd0);
    check("ill_err",       32'(rsp_err),  32'd1);
    check("ill_data",      32'(rsp_data), 32'h0000);
    check("ill_zero",      32'(rsp_zero), 32'd0);
    @(negedge clk);
    check("ill_ops_done",  32'(ops_done), 32'd3);
    check("ill_no_enable", 32'(enable),   32'd0);

    // ADD wrapping to zero: rsp_zero depends on the zero-source build option
    send(4'h1, 16'hFFFF, 16'h0001);
    wait_rsp(en_cnt, waited);
    check("addw_data", 32'(rsp_data), 32'h0000);
    check("addw_err",  32'(rsp_err),  32'd0);
    check("addw_zero", 32'(rsp_zero), 32'(exp_zero_add));
    @(negedge clk);
    check("addw_ops_done", 32'(ops_done), 32'd4);

    // ops_done wrap, starting from a preloaded 0xFFFE to stay within the cycle budget
    force dut.ops_q = 16'hFFFE;
    @(negedge clk);
    release dut.ops_q;
    send(4'h4, 16'h0000, 16'h5A5A);
    wait_rsp(en_cnt, waited);
    check("passb_data", 32'(rsp_data), 32'h5A5A);
    @(negedge clk);
    check("wrap_ffff", 32'(ops_done), 32'hFFFF);
    send(4'h4, 16'h0000, 16'h0003);
    wait_rsp(en_cnt, waited);
    @(negedge clk);
    check("wrap_zero", 32'(ops_done), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
